cmd_dispatcher: RTL and testbench
=================================

Name: cmd_dispatcher

Overview:
Parametrised UART command dispatcher for the vector coprocessor. It decodes each received command byte into a one-hot operation enable and a bank select. The enable is held until the addressed engine reports done. The block also provides a one-entry pending buffer, illegal-opcode and bank checks, and a per-command watchdog. It sits between the UART RX and the write/read/arithmetic engines.

Parameters:
DATA_W, 8, RX byte width
OP_W, 3, opcode field width (rx_data[OP_W-1:0])
N_CMDS, 7, number of legal opcodes (1..N_CMDS); N_CMDS <= 2**OP_W-1
NUM_BANKS, 2, number of vector BRAM banks
BANK_W, max(1,$clog2(NUM_BANKS)), bank field width (rx_data[DATA_W-1 -: BANK_W]); BANK_W+OP_W <= DATA_W
TIMEOUT_CYCLES, 0, watchdog limit in RUN cycles; 0 disables

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rx_ready  in  1  one-cycle strobe, rx_data valid
rx_data  in  DATA_W  command byte
done  in  N_CMDS  per-engine done; only the bit of the active command counts
command_out  out  N_CMDS  one-hot enable; opcode k -> bit N_CMDS-k (Write=MSB ... Dot=LSB)
bank_sel  out  BANK_W  latched bank field of active command
cmd_start  out  1  one-cycle pulse on issue
busy  out  1  high in ISSUE and RUN
pending_full  out  1  pending buffer occupied
err_illegal  out  1  one-cycle pulse: bad opcode or bank
err_timeout  out  1  one-cycle pulse: watchdog expired
err_overrun  out  1  one-cycle pulse: byte dropped

Behaviour:
- Reset: state IDLE. command_out, bank_sel, cmd_start, busy, pending_full, and all err_* are 0. Pending buffer and watchdog are cleared. Reset mid-command aborts it and drops any pending byte.
- FSM states: IDLE, ISSUE, RUN.
- Candidate byte in IDLE: the pending buffer if full, else rx_data if rx_ready.
- Simultaneous pending and rx_ready in IDLE: pending is consumed; the new byte is written to pending.
- Validation in IDLE: opcode 0, opcode > N_CMDS, or bank >= NUM_BANKS -> err_illegal next cycle, byte discarded, stay IDLE.
- Valid byte in IDLE at cycle t: latch opcode/bank; go to ISSUE at t+1.
  - At t+1: cmd_start=1, busy=1, command_out one-hot, bank_sel valid.
- ISSUE: always moves to RUN, unless the active done bit is high; then it goes to IDLE.
- RUN: active done bit high at cycle t -> IDLE at t+1, with command_out=0 and busy=0 at t+1.
  - The next command can enter ISSUE no earlier than t+2.
- Outputs are registered. command_out and bank_sel are stable for the whole ISSUE..RUN span and 0 in IDLE.
- Watchdog (TIMEOUT_CYCLES>0): counter is cleared in ISSUE and increments each RUN cycle without done.
  - When the counter reaches TIMEOUT_CYCLES-1 with no done -> err_timeout pulse and IDLE next cycle.
  - done in the same cycle as expiry wins: no error.
- Done bits other than the active one are ignored.
- rx_ready while busy, pending empty: byte stored unvalidated; pending_full=1 next cycle.
- rx_ready while busy, pending full: err_overrun pulse; new byte dropped; pending byte kept.

Decomposition:
- Package cmd_pkg holds:
  - FSM state enum.
  - Opcode localparams: OP_WRITE=1, OP_READ=2, OP_SUM=3, OP_AVG=4, OP_EUC=5, OP_MAN=6, OP_DOT=7.
  - Function op2onehot(opcode, N_CMDS).
- Sub-module cmd_pending_buf: one-entry register with push/pop, full flag, and overrun pulse. Its push and pop ports resolve simultaneous operations.

Test Plan:
- Defaults. rx_ready with 0x81 (bank 1, Write) at t -> at t+1 cmd_start=1, command_out=7'b1000000, bank_sel=1, busy=1. done[6] at t+5 -> command_out=0 and busy=0 at t+6.
- Byte 0x07 (Dot): command_out=7'b0000001. done[3] pulses are ignored and command_out holds. done[0] ends the command.
- Bytes 0x00 and 0x08: with OP_W=3, 0x08 decodes to opcode 0. Each gives one err_illegal pulse, no cmd_start, stays IDLE. Repeat with NUM_BANKS=1 and byte 0x81 -> err_illegal.
- During a Sum: send 0x02 -> pending_full=1. Send 0x05 -> err_overrun pulse. After done[4] -> Read issues two cycles later, then pending_full=0.
- TIMEOUT_CYCLES=4 with Avg and no done: err_timeout at the 4th RUN cycle, IDLE next. Second run with done on that cycle -> no err_timeout.
- Assert reset during RUN with pending full: next cycle all outputs 0, pending_full=0, and no command issues after reset deasserts.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared types and helpers for the UART command dispatcher.
// Opcode map, FSM states and opcode-to-enable decode.
package cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RUN
    } state_e;

    localparam int OP_WRITE = 1;
    localparam int OP_READ  = 2;
    localparam int OP_SUM   = 3;
    localparam int OP_AVG   = 4;
    localparam int OP_EUC   = 5;
    localparam int OP_MAN   = 6;
    localparam int OP_DOT   = 7;

    // Opcode k maps to bit n_cmds-k, so Write lands on the MSB.
    function automatic logic [31:0] op2onehot(
        input int unsigned opcode,
        input int unsigned n_cmds
    );
        logic [31:0] oh;
        oh = '0;
        if (opcode != 0 && opcode <= n_cmds)
            oh = 32'd1 << (n_cmds - opcode);
        return oh;
    endfunction

endpackage

// File: rtl/cmd_pending_buf.sv
// One-entry holding register for a command byte that arrives while busy.
// A push into a full entry is dropped and flagged unless the entry is popped in the same cycle.
module cmd_pending_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              overrun_o
);

    logic [DATA_W-1:0] data_q;
    logic              full_q;
    logic              ovr_q;

    // Store, replace or release the held byte; pulse overrun on a dropped push.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            full_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (push_i) begin
                if (full_q && !pop_i) begin
                    ovr_q <= 1'b1;
                end else begin
                    data_q <= data_i;
                    full_q <= 1'b1;
                end
            end else if (pop_i) begin
                full_q <= 1'b0;
            end
        end
    end

    assign data_o    = data_q;
    assign full_o    = full_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/cmd_dispatcher.sv
// Decodes UART command bytes into a held one-hot engine enable plus bank select.
// Adds a one-entry pending buffer, opcode/bank checking and an optional watchdog.
module cmd_dispatcher
    import cmd_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int OP_W           = 3,
    parameter int N_CMDS         = 7,
    parameter int NUM_BANKS      = 2,
    parameter int BANK_W         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic [N_CMDS-1:0] done,
    output logic [N_CMDS-1:0] command_out,
    output logic [BANK_W-1:0] bank_sel,
    output logic              cmd_start,
    output logic              busy,
    output logic              pending_full,
    output logic              err_illegal,
    output logic              err_timeout,
    output logic              err_overrun
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q;
    logic [N_CMDS-1:0] cmd_q;
    logic [BANK_W-1:0] bank_q;
    logic              start_q;
    logic              busy_q;
    logic              ill_q;
    logic              tmo_q;
    logic [WD_W-1:0]   wd_q;

    logic              pend_full;
    logic [DATA_W-1:0] pend_data;
    logic              pend_push;
    logic              pend_pop;
    logic              pend_ovr;

    logic              cand_valid;
    logic [DATA_W-1:0] cand_byte;
    logic [OP_W-1:0]   cand_op;
    logic [BANK_W-1:0] cand_bank;
    logic              cand_ok;
    logic [N_CMDS-1:0] cand_oh;
    logic              act_done;
    logic              wd_exp;
    logic              unused_cand;

    cmd_pending_buf #(
        .DATA_W (DATA_W)
    ) u_pend (
        .clk       (clk),
        .reset     (reset),
        .push_i    (pend_push),
        .pop_i     (pend_pop),
        .data_i    (rx_data),
        .data_o    (pend_data),
        .full_o    (pend_full),
        .overrun_o (pend_ovr)
    );

    // Pick the byte to consider in IDLE and route incoming bytes to the buffer.
    always_comb begin
        cand_valid = 1'b0;
        cand_byte  = rx_data;
        pend_pop   = 1'b0;
        pend_push  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (pend_full) begin
                cand_valid = 1'b1;
                cand_byte  = pend_data;
                pend_pop   = 1'b1;
                pend_push  = rx_ready;
            end else begin
                cand_valid = rx_ready;
            end
        end else begin
            pend_push = rx_ready;
        end
        cand_op   = cand_byte[OP_W-1:0];
        cand_bank = cand_byte[DATA_W-1 -: BANK_W];
        cand_ok   = (cand_op != '0) &&
                    (int'(cand_op) <= N_CMDS) &&
                    (int'(cand_bank) < NUM_BANKS);
        cand_oh   = N_CMDS'(op2onehot(int'(cand_op), N_CMDS));
        act_done  = |(done & cmd_q);
        wd_exp    = (TIMEOUT_CYCLES > 0) && (wd_q == WD_LAST);
    end

    assign unused_cand = ^cand_byte;

    // Command FSM: issue, hold the enable until done or watchdog expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            bank_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ill_q   <= 1'b0;
            tmo_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            start_q <= 1'b0;
            ill_q   <= 1'b0;
            tmo_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cand_valid) begin
                        if (cand_ok) begin
                            state_q <= ST_ISSUE;
                            cmd_q   <= cand_oh;
                            bank_q  <= cand_bank;
                            start_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            ill_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    wd_q <= '0;
                    if (act_done) begin
                        state_q <= ST_IDLE;
                        cmd_q   <= '0;
                        bank_q  <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (act_done || wd_exp) begin
                        state_q <= ST_IDLE;
                        cmd_q   <= '0;
                        bank_q  <= '0;
                        busy_q  <= 1'b0;
                        tmo_q   <= !act_done;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cmd_q   <= '0;
                    bank_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign command_out  = cmd_q;
    assign bank_sel     = bank_q;
    assign cmd_start    = start_q;
    assign busy         = busy_q;
    assign pending_full = pend_full;
    assign err_illegal  = ill_q;
    assign err_timeout  = tmo_q;
    assign err_overrun  = pend_ovr;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher: default, single-bank and watchdog builds.
// Per-cycle vector table plus hand sequences for timeout and reset abort.
module tb_cmd_dispatcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic [6:0] done;

    logic [6:0] cmd   [3];
    logic       bank  [3];
    logic       start [3];
    logic       bsy   [3];
    logic       pf    [3];
    logic       eil   [3];
    logic       eto   [3];
    logic       eov   [3];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rdy;
        logic [7:0]  data;
        logic [6:0]  dn;
        logic [13:0] exp;
    } vec_t;

    vec_t tv[$];

    always #5 clk = ~clk;

    cmd_dispatcher u0 (
        .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
        .done(done), .command_out(cmd[0]), .bank_sel(bank[0]),
        .cmd_start(start[0]), .busy(bsy[0]), .pending_full(pf[0]),
        .err_illegal(eil[0]), .err_timeout(eto[0]), .err_overrun(eov[0])
    );

    cmd_dispatcher #(.NUM_BANKS(1)) u1 (
        .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
        .done(done), .command_out(cmd[1]), .bank_sel(bank[1]),
        .cmd_start(start[1]), .busy(bsy[1]), .pending_full(pf[1]),
        .err_illegal(eil[1]), .err_timeout(eto[1]), .err_overrun(eov[1])
    );

    cmd_dispatcher #(.TIMEOUT_CYCLES(4)) u2 (
        .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
        .done(done), .command_out(cmd[2]), .bank_sel(bank[2]),
        .cmd_start(start[2]), .busy(bsy[2]), .pending_full(pf[2]),
        .err_illegal(eil[2]), .err_timeout(eto[2]), .err_overrun(eov[2])
    );

    function automatic logic [13:0] outs(input int k);
        return {cmd[k], bank[k], start[k], bsy[k], pf[k], eil[k], eto[k], eov[k]};
    endfunction

    // cmd, bank, start, busy, pending_full, illegal, timeout, overrun
    function automatic logic [13:0] E(
        input logic [6:0] c, input logic b, input logic st, input logic bs,
        input logic p, input logic il, input logic to, input logic ov
    );
        return {c, b, st, bs, p, il, to, ov};
    endfunction

    task automatic check(input string name, input int k, input logic [13:0] exp);
        n_cmp++;
        if (outs(k) !== exp) begin
            n_bad++;
            $display("FAIL %s (dut%0d): got %b required %b", name, k, outs(k), exp);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] d, input logic [6:0] dn);
        rx_ready = r;
        rx_data  = d;
        done     = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 8'h00, 7'h00);
        step(1'b0, 8'h00, 7'h00);
        reset = 1'b0;
    endtask

    initial begin
        logic [13:0] z;
        z = '0;
        reset    = 1'b1;
        rx_ready = 1'b0;
        rx_data  = '0;
        done     = '0;

        // Write / Dot / illegal / pending / back-to-back sequences on u0
        tv.push_back('{1'b1, 8'h81, 7'h00, E(7'b1000000,1,1,1,0,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'h00, E(7'b1000000,1,0,1,0,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'h00, E(7'b1000000,1,0,1,0,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'h00, E(7'b1000000,1,0,1,0,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'b1000000, z});
        tv.push_back('{1'b1, 8'h07, 7'h00, E(7'b0000001,0,1,1,0,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'b0001000, E(7'b0000001,0,0,1,0,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'b0001000, E(7'b0000001,0,0,1,0,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'b0000001, z});
        tv.push_back('{1'b1, 8'h00, 7'h00, E(7'b0,0,0,0,0,1,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'h00, z});
        tv.push_back('{1'b1, 8'h08, 7'h00, E(7'b0,0,0,0,0,1,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'h00, z});
        tv.push_back('{1'b1, 8'h03, 7'h00, E(7'b0010000,0,1,1,0,0,0,0)});
        tv.push_back('{1'b1, 8'h02, 7'h00, E(7'b0010000,0,0,1,1,0,0,0)});
        tv.push_back('{1'b1, 8'h05, 7'h00, E(7'b0010000,0,0,1,1,0,0,1)});
        tv.push_back('{1'b0, 8'h00, 7'h00, E(7'b0010000,0,0,1,1,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'b0010000, E(7'b0,0,0,0,1,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'h00, E(7'b0100000,0,1,1,0,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'b0100000, z});
        tv.push_back('{1'b1, 8'h84, 7'h00, E(7'b0001000,1,1,1,0,0,0,0)});
        tv.push_back('{1'b1, 8'h85, 7'h00, E(7'b0001000,1,0,1,1,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'b0001000, E(7'b0,0,0,0,1,0,0,0)});
        tv.push_back('{1'b1, 8'h06, 7'h00, E(7'b0000100,1,1,1,1,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'b0000100, E(7'b0,0,0,0,1,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'h00, E(7'b0000010,0,1,1,0,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'b0000010, z});
        tv.push_back('{1'b1, 8'h01, 7'h00, E(7'b1000000,0,1,1,0,0,0,0)});
        tv.push_back('{1'b1, 8'h00, 7'h00, E(7'b1000000,0,0,1,1,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'b1000000, E(7'b0,0,0,0,1,0,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'h00, E(7'b0,0,0,0,0,1,0,0)});
        tv.push_back('{1'b0, 8'h00, 7'h00, z});

        do_reset();
        for (int k = 0; k < 3; k++) check("reset", k, z);

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].rdy, tv[i].data, tv[i].dn);
            check($sformatf("vec%0d", i), 0, tv[i].exp);
        end

        // single-bank build rejects bank 1
        do_reset();
        step(1'b1, 8'h81, 7'h00);
        check("bank1_illegal", 1, E(7'b0,0,0,0,0,1,0,0));
        step(1'b0, 8'h00, 7'h00);
        check("bank1_idle", 1, z);

        // watchdog: Avg with no done expires after four RUN cycles
        do_reset();
        step(1'b1, 8'h04, 7'h00);
        check("wd_issue", 2, E(7'b0001000,0,1,1,0,0,0,0));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 7'h00);
            check($sformatf("wd_run%0d", i), 2, E(7'b0001000,0,0,1,0,0,0,0));
        end
        step(1'b0, 8'h00, 7'h00);
        check("wd_run3", 2, E(7'b0001000,0,0,1,0,0,0,0));
        step(1'b0, 8'h00, 7'h00);
        check("wd_expire", 2, E(7'b0,0,0,0,0,0,1,0));
        step(1'b0, 8'h00, 7'h00);
        check("wd_after", 2, z);

        // watchdog: done on the expiry cycle wins
        step(1'b1, 8'h04, 7'h00);
        check("wd2_issue", 2, E(7'b0001000,0,1,1,0,0,0,0));
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 7'h00);
        check("wd2_last", 2, E(7'b0001000,0,0,1,0,0,0,0));
        step(1'b0, 8'h00, 7'b0001000);
        check("wd2_done_wins", 2, z);

        // reset while running with a pending byte
        do_reset();
        step(1'b1, 8'h81, 7'h00);
        step(1'b1, 8'h02, 7'h00);
        check("rst_pend", 0, E(7'b1000000,1,0,1,1,0,0,0));
        step(1'b0, 8'h00, 7'h00);
        reset = 1'b1;
        step(1'b0, 8'h00, 7'h00);
        check("rst_abort", 0, z);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 7'h00);
            check($sformatf("rst_quiet%0d", i), 0, z);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
